enc_bundler_accum: RTL and testbench

Downstream stage of the encoder's binder packs. It consumes the shifted (bound) hypervectors that a binder pack produces, ten lanes per beat, and accumulates a per-bit count across all features of one sample. Once the last feature beat has arrived, it thresholds the counts into a sparse query hypervector and presents that vector to the classifier with a valid/ready handshake.

---
 rtl/enc_bundler_accum.sv | 134 +++++++++++++
 tb/tb_enc_bundler_accum.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/enc_bundler_accum.sv
// enc_bundler_accum: accumulates per-bit counts of bound hypervectors, PACK_WIDTH
// lanes per beat, over all features of one sample. It then thresholds the counts
// into a sparse query hypervector and offers it to the classifier.
//
// Handshakes (both ports): a transfer happens on a rising edge where valid and
// ready are both high. in_ready is high exactly while the FSM is in ACCUM.
// query_valid is high exactly while in DONE. Once query_valid is raised, it and
// query_hv hold until query_ready is seen or start_encoding aborts the sample.
`timescale 1ns/1ps
module enc_bundler_accum #(
  parameter int HV_DIM       = 1024,
  parameter int PACK_WIDTH   = 10,
  parameter int NUM_FEATURES = 617,
  parameter int THRESHOLD    = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start_encoding,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [HV_DIM-1:0] shifted_hv [0:PACK_WIDTH-1],
  output logic              query_valid,
  input  logic              query_ready,
  output logic [HV_DIM-1:0] query_hv,
  output logic              busy,
  output logic [1:0]        state_dbg
);

  localparam int NUM_BEATS  = (NUM_FEATURES + PACK_WIDTH - 1) / PACK_WIDTH;
  localparam int CNT_W      = $clog2(NUM_FEATURES + 1);
  localparam int BEAT_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int SUM_W      = $clog2(PACK_WIDTH + 1);
  // The final beat carries 1..PACK_WIDTH real features. The lanes above that are padding.
  localparam int LAST_LANES = NUM_FEATURES - (NUM_BEATS - 1) * PACK_WIDTH;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCUM  = 2'd1,
    THRESH = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t            state;
  logic [BEAT_W-1:0] beat_cnt;
  logic [CNT_W-1:0]  cnt      [HV_DIM];
  logic [CNT_W-1:0]  cnt_next [HV_DIM];
  logic [SUM_W-1:0]  lane_sum [HV_DIM];
  logic [PACK_WIDTH-1:0] lane_en;
  logic              last_beat;
  logic              beat_fire;

  assign state_dbg = state;
  assign last_beat = (beat_cnt == BEAT_W'(NUM_BEATS - 1));
  assign beat_fire = (state == ACCUM) && in_valid;

  // Lane enables: on the final beat, drop the lanes past the last real feature.
  always_comb begin
    lane_en = '1;
    for (int l = 0; l < PACK_WIDTH; l++) begin
      if (last_beat && (l >= LAST_LANES)) lane_en[l] = 1'b0;
    end
  end

  // Per-bit popcount over the active lanes, added to the running count in one stage.
  always_comb begin
    for (int b = 0; b < HV_DIM; b++) begin
      lane_sum[b] = '0;
      for (int l = 0; l < PACK_WIDTH; l++) begin
        lane_sum[b] = lane_sum[b] + SUM_W'(lane_en[l] & shifted_hv[l][b]);
      end
      cnt_next[b] = cnt[b] + CNT_W'(lane_sum[b]);
    end
  end

  // Control FSM with registered handshake outputs, counters and query register.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      beat_cnt    <= '0;
      in_ready    <= 1'b0;
      query_valid <= 1'b0;
      query_hv    <= '0;
      busy        <= 1'b0;
      for (int b = 0; b < HV_DIM; b++) cnt[b] <= '0;
    end else if (start_encoding) begin
      // A new sample always wins, even over a beat or query transfer in this cycle.
      state       <= ACCUM;
      beat_cnt    <= '0;
      in_ready    <= 1'b1;
      query_valid <= 1'b0;
      busy        <= 1'b1;
      for (int b = 0; b < HV_DIM; b++) cnt[b] <= '0;
    end else begin
      case (state)
        IDLE: begin
          in_ready    <= 1'b0;
          query_valid <= 1'b0;
          busy        <= 1'b0;
        end
        ACCUM: begin
          if (beat_fire) begin
            for (int b = 0; b < HV_DIM; b++) cnt[b] <= cnt_next[b];
            beat_cnt <= beat_cnt + 1'b1;
            if (last_beat) begin
              state    <= THRESH;
              in_ready <= 1'b0;
            end
          end
        end
        THRESH: begin
          for (int b = 0; b < HV_DIM; b++) begin
            query_hv[b] <= (cnt[b] >= CNT_W'(THRESHOLD));
          end
          state       <= DONE;
          query_valid <= 1'b1;
        end
        DONE: begin
          if (query_ready) begin
            state       <= IDLE;
            query_valid <= 1'b0;
            busy        <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready    <= 1'b0;
          query_valid <= 1'b0;
          busy        <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_enc_bundler_accum.sv
// Bench for enc_bundler_accum with a small configuration: 8-bit vectors, 25 features
// (3 beats of 10 lanes) and threshold 12. The reference model walks the feature
// list directly and counts set bits per position.
`timescale 1ns/1ps
module tb_enc_bundler_accum;

  localparam int HV_DIM       = 8;
  localparam int PACK_WIDTH   = 10;
  localparam int NUM_FEATURES = 25;
  localparam int THRESHOLD    = 12;
  localparam int NUM_BEATS    = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  logic              start_encoding = 1'b0;
  logic              in_valid = 1'b0;
  logic              query_ready = 1'b0;
  logic              in_ready;
  logic              query_valid;
  logic              busy;
  logic [HV_DIM-1:0] query_hv;
  logic [1:0]        state_dbg;
  logic [HV_DIM-1:0] shifted_hv [0:PACK_WIDTH-1];

  logic [HV_DIM-1:0] beat_buf [NUM_BEATS][PACK_WIDTH];
  logic [HV_DIM-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  enc_bundler_accum #(
    .HV_DIM(HV_DIM), .PACK_WIDTH(PACK_WIDTH),
    .NUM_FEATURES(NUM_FEATURES), .THRESHOLD(THRESHOLD)
  ) dut (
    .clk(clk), .nrst(nrst), .start_encoding(start_encoding),
    .in_valid(in_valid), .in_ready(in_ready), .shifted_hv(shifted_hv),
    .query_valid(query_valid), .query_ready(query_ready), .query_hv(query_hv),
    .busy(busy), .state_dbg(state_dbg)
  );

  initial begin
    #500000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard / checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  // Reference: count each bit over features 0..NUM_FEATURES-1, then threshold.
  function automatic logic [HV_DIM-1:0] model_query();
    int cnt [HV_DIM];
    logic [HV_DIM-1:0] q;
    for (int b = 0; b < HV_DIM; b++) cnt[b] = 0;
    for (int f = 0; f < NUM_FEATURES; f++) begin
      for (int b = 0; b < HV_DIM; b++) begin
        if (beat_buf[f / PACK_WIDTH][f % PACK_WIDTH][b]) cnt[b]++;
      end
    end
    for (int b = 0; b < HV_DIM; b++) q[b] = (cnt[b] >= THRESHOLD);
    return q;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [HV_DIM-1:0] v);
    for (int k = 0; k < NUM_BEATS; k++)
      for (int l = 0; l < PACK_WIDTH; l++) beat_buf[k][l] = v;
  endtask

  task automatic fill_random();
    int mode;
    logic [HV_DIM-1:0] v;
    mode = $urandom_range(0, 2);
    for (int k = 0; k < NUM_BEATS; k++) begin
      for (int l = 0; l < PACK_WIDTH; l++) begin
        case (mode)
          0:       v = HV_DIM'($urandom & $urandom);
          1:       v = HV_DIM'($urandom);
          default: v = HV_DIM'($urandom | $urandom);
        endcase
        beat_buf[k][l] = v;
      end
    end
  endtask

  task automatic drive_beat(input int k);
    for (int l = 0; l < PACK_WIDTH; l++) shifted_hv[l] = beat_buf[k][l];
    in_valid = 1'b1;
  endtask

  task automatic pulse_start();
    start_encoding = 1'b1;
    step();
    start_encoding = 1'b0;
  endtask

  // One full sample: optional start, NUM_BEATS beats, then the query handshake
  // after `hold` extra cycles of backpressure.
  task automatic run_sample(input bit do_start, input bit gaps, input int hold);
    logic [HV_DIM-1:0] exp;
    if (do_start) begin
      pulse_start();
      check("rdy_after_start", in_ready, 1);
      check("busy_after_start", busy, 1);
    end
    exp_q.push_back(model_query());
    for (int k = 0; k < NUM_BEATS; k++) begin
      if (gaps && k > 0) begin
        in_valid = 1'b0;
        step();
        check("rdy_gap", in_ready, 1);
      end
      drive_beat(k);
      check("rdy_accum", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    check("rdy_thresh", in_ready, 0);
    check("qv_thresh", query_valid, 0);
    check("state_thresh", state_dbg, 2);
    query_ready = (hold == 0);
    step();
    exp = exp_q.pop_front();
    check("qv_latency", query_valid, 1);
    check("query_hv", query_hv, exp);
    check("state_done", state_dbg, 3);
    for (int h = 0; h < hold; h++) begin
      step();
      check("qv_hold", query_valid, 1);
      check("hv_hold", query_hv, exp);
    end
    query_ready = 1'b1;
    step();
    query_ready = 1'b0;
    check("qv_drop", query_valid, 0);
    check("busy_drop", busy, 0);
    check("state_idle", state_dbg, 0);
    check("hv_kept", query_hv, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int l = 0; l < PACK_WIDTH; l++) shifted_hv[l] = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_qv", query_valid, 0);
    check("rst_hv", query_hv, 0);
    check("rst_busy", busy, 0);
    check("rst_state", state_dbg, 0);
    nrst = 1'b1;
    step();

    // Reset in the middle of accumulation.
    fill(8'hFF);
    pulse_start();
    drive_beat(0);
    step();
    in_valid = 1'b0;
    check("state_accum", state_dbg, 1);
    nrst = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 0);
    check("midrst_qv", query_valid, 0);
    check("midrst_hv", query_hv, 0);
    check("midrst_busy", busy, 0);
    check("midrst_state", state_dbg, 0);
    step();
    nrst = 1'b1;
    step();

    // Beats offered while idle are ignored.
    for (int i = 0; i < 4; i++) begin
      drive_beat(0);
      step();
      check("rdy_idle", in_ready, 0);
      check("state_idle_pulse", state_dbg, 0);
    end
    in_valid = 1'b0;

    // Sample from zero: bit 0 in 11 features -> below threshold.
    fill(8'h00);
    for (int f = 0; f < 11; f++) beat_buf[f / PACK_WIDTH][f % PACK_WIDTH] = 8'h01;
    run_sample(1, 0, 0);

    // All ones.
    fill(8'hFF);
    run_sample(1, 0, 0);

    // Lane masking: only padding lanes carry ones.
    fill(8'h00);
    for (int l = 5; l < PACK_WIDTH; l++) beat_buf[2][l] = 8'hFF;
    run_sample(1, 0, 0);

    // Threshold edge: bit0 in 12 features, bit1 in 11, padding lanes set.
    fill(8'h00);
    for (int f = 0; f < 12; f++) beat_buf[f / PACK_WIDTH][f % PACK_WIDTH] |= 8'h01;
    for (int f = 12; f < 23; f++) beat_buf[f / PACK_WIDTH][f % PACK_WIDTH] |= 8'h02;
    for (int l = 5; l < PACK_WIDTH; l++) beat_buf[2][l] = 8'hFF;
    run_sample(1, 0, 0);

    // Backpressure, then the same data with gaps between beats.
    fill_random();
    run_sample(1, 0, 5);
    run_sample(1, 1, 0);

    // Abort during beat 2; the beat offered with start_encoding is dropped.
    fill(8'hFF);
    pulse_start();
    for (int k = 0; k < 2; k++) begin
      drive_beat(k);
      step();
    end
    drive_beat(2);
    start_encoding = 1'b1;
    step();
    start_encoding = 1'b0;
    in_valid = 1'b0;
    check("abort_state", state_dbg, 1);
    check("abort_rdy", in_ready, 1);
    check("abort_qv", query_valid, 0);
    fill(8'h0F);
    run_sample(0, 0, 0);

    // Abort in DONE, colliding with a query handshake: start wins.
    fill(8'hFF);
    pulse_start();
    for (int k = 0; k < NUM_BEATS; k++) begin
      drive_beat(k);
      step();
    end
    in_valid = 1'b0;
    step();
    check("done_qv", query_valid, 1);
    query_ready = 1'b1;
    start_encoding = 1'b1;
    step();
    start_encoding = 1'b0;
    query_ready = 1'b0;
    check("done_abort_qv", query_valid, 0);
    check("done_abort_state", state_dbg, 1);
    check("done_abort_busy", busy, 1);
    check("done_abort_rdy", in_ready, 1);
    fill_random();
    run_sample(0, 0, 0);

    // Randomized samples.
    repeat (10) begin
      fill_random();
      run_sample(1, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
